// File: rtl/cbm_pkg.sv
// -----------------------------------------------------------------------------
// cbm_pkg
// Shared encodings for the CBM burst responder: burst and size codes, the
// responder FSM state type, the registered command record, and small helpers
// for beat-count decode and per-beat address sequencing.
// -----------------------------------------------------------------------------
package cbm_pkg;

    // Burst type encodings on cbm_burst; every other code is illegal.
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;

    // The only legal transfer size (32-bit word).
    localparam logic [2:0] SIZE_WORD    = 3'b010;

    // Width of the beat counter and of the decoded beat total.
    localparam int unsigned CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        READ,
        ERR
    } state_e;

    // Command captured on accept. addr always holds the byte address of the
    // next beat to be issued to the memory.
    typedef struct packed {
        logic [2:0]       burst;
        logic [31:0]      addr;
        logic [CNT_W-1:0] total;
    } cmd_t;

    function automatic logic burst_legal(input logic [2:0] burst);
        return (burst == BURST_SINGLE) || (burst == BURST_INCR) || (burst == BURST_WRAP4);
    endfunction

    // Beats in a command. An INCR length of zero encodes the maximum, 1024.
    function automatic logic [CNT_W-1:0] beat_total(input logic [2:0]       burst,
                                                    input logic [CNT_W-1:0] length);
        logic [CNT_W-1:0] total;
        case (burst)
            BURST_WRAP4: total = 11'd4;
            BURST_INCR:  total = (length == '0) ? 11'd1024 : length;
            default:     total = 11'd1;
        endcase
        return total;
    endfunction

    // Address of the beat following addr. WRAP4 stays inside its 16-byte
    // aligned block by incrementing only the word-select bits [3:2].
    function automatic logic [31:0] next_beat_addr(input logic [2:0]  burst,
                                                   input logic [31:0] addr);
        logic [1:0] word;
        word = addr[3:2] + 2'd1;
        if (burst == BURST_WRAP4) begin
            return {addr[31:4], word, 2'b00};
        end
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/cbm_resp_mem.sv
// -----------------------------------------------------------------------------
// cbm_resp_mem
// Single-port 2^AW x 32 local memory for the burst responder. Writes and
// reads are both synchronous; read data appears one cycle after the address.
// A write returns the previous contents on rdata (read-before-write).
//
// Ports
//   clk    in   clock
//   we     in   write enable for addr
//   addr   in   word address (AW bits)
//   wdata  in   write data
//   rdata  out  registered read data for the address of the previous cycle
// -----------------------------------------------------------------------------
module cbm_resp_mem #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // NOTE: the array and its read register carry no reset; the contents must
    // survive a reset, and a reset port would stop the array mapping to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cbm_burst_responder.sv
// -----------------------------------------------------------------------------
// cbm_burst_responder
// Target-side responder for CBM burst commands backed by a local word memory
// mapped at BASE_ADDR .. BASE_ADDR + 4*2^AW_WORDS - 1. A command is accepted
// in IDLE on the cycle its request is sampled; illegal commands spend one
// cycle in ERR. Writes take one beat per cycle starting the cycle after
// accept; reads spend one cycle in RD_ADDR for the memory latency, then
// stream one beat per cycle.
//
// Ports
//   bus1_HCLK         in   clock, rising edge
//   bus1_HRESETn      in   synchronous active-low reset
//   cbm_read_req      in   read command request
//   cbm_write_req     in   write command request
//   cbm_burst[2:0]    in   SINGLE / INCR / WRAP4
//   cbm_addr[31:0]    in   start byte address
//   cbm_length[10:0]  in   INCR beat count, 0 = 1024
//   cbm_size[2:0]     in   transfer size, word only
//   cbm_lock          in   locked-transfer hint, no effect
//   cbm_write_data    in   write beat data
//   cbm_read_data     out  read beat data, zero outside read beats
//   cbm_command_busy  out  command in progress
//   cbm_data_ready    out  one pulse per completed beat
//   cbm_error         out  one pulse per rejected command
//   cbm_count[10:0]   out  beats completed in the current/last command
// -----------------------------------------------------------------------------
module cbm_burst_responder
    import cbm_pkg::*;
#(
    parameter int unsigned AW_WORDS  = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             bus1_HCLK,
    input  logic             bus1_HRESETn,
    input  logic             cbm_read_req,
    input  logic             cbm_write_req,
    input  logic [2:0]       cbm_burst,
    input  logic [31:0]      cbm_addr,
    input  logic [CNT_W-1:0] cbm_length,
    input  logic [2:0]       cbm_size,
    input  logic             cbm_lock,
    input  logic [31:0]      cbm_write_data,
    output logic [31:0]      cbm_read_data,
    output logic             cbm_command_busy,
    output logic             cbm_data_ready,
    output logic             cbm_error,
    output logic [CNT_W-1:0] cbm_count
);

    // Window size in bytes, kept at 34 bits so offset + span never overflows.
    localparam logic [33:0] WIN_BYTES = 34'd4 << AW_WORDS;

    state_e           state, state_nxt;
    cmd_t             cmd, cmd_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;

    logic             any_req;
    logic [CNT_W-1:0] req_total;
    logic [31:0]      req_first;
    logic [33:0]      req_off;
    logic [33:0]      req_end;
    logic             req_in_range;
    logic             req_bad;

    logic             last_beat;
    logic             mem_we;
    logic [31:0]      word_off;
    logic [AW_WORDS-1:0] mem_addr;
    logic [31:0]      mem_rdata;

    // ------------------------------------------------------------------
    // Command legality, evaluated on the request inputs in IDLE.
    // The lowest byte touched is the start address, except for WRAP4 where
    // it is the aligned 16-byte block; the span is 4 bytes per beat.
    // A start below BASE_ADDR shows up as bit 33 of the 34-bit difference.
    // ------------------------------------------------------------------
    assign any_req = cbm_read_req | cbm_write_req;

    always_comb begin
        req_total    = beat_total(cbm_burst, cbm_length);
        req_first    = (cbm_burst == BURST_WRAP4) ? {cbm_addr[31:4], 4'b0000} : cbm_addr;
        req_off      = {2'b00, req_first} - {2'b00, BASE_ADDR};
        req_end      = req_off + {21'd0, req_total, 2'b00};
        req_in_range = !req_off[33] && (req_end <= WIN_BYTES);
        req_bad      = (cbm_read_req && cbm_write_req)
                    || (cbm_size != SIZE_WORD)
                    || (cbm_addr[1:0] != 2'b00)
                    || !burst_legal(cbm_burst)
                    || !req_in_range;
    end

    // Memory word index of the beat currently being issued.
    assign word_off  = cmd.addr - BASE_ADDR;
    assign mem_addr  = word_off[AW_WORDS+1:2];

    // count_q holds the beats already completed, so the beat in flight is
    // the last one when it equals total-1 (total is 1..1024, never 0).
    assign last_beat = (count_q == cmd.total - 11'd1);

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        count_nxt = count_q;
        mem_we    = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    cmd_nxt.burst = cbm_burst;
                    cmd_nxt.addr  = cbm_addr;
                    cmd_nxt.total = req_total;
                    count_nxt     = '0;
                    if (req_bad) begin
                        state_nxt = ERR;
                    end else if (cbm_write_req) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end

            WRITE: begin
                mem_we       = 1'b1;
                cmd_nxt.addr = next_beat_addr(cmd.burst, cmd.addr);
                count_nxt    = count_q + 11'd1;
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end

            // First address goes to the memory; its data returns in READ.
            RD_ADDR: begin
                cmd_nxt.addr = next_beat_addr(cmd.burst, cmd.addr);
                state_nxt    = READ;
            end

            // Present the beat fetched last cycle while issuing the next
            // address. The address issued alongside the final beat is never
            // consumed; reads have no side effects so it is left alone.
            READ: begin
                cmd_nxt.addr = next_beat_addr(cmd.burst, cmd.addr);
                count_nxt    = count_q + 11'd1;
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end

            ERR: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge bus1_HCLK) begin
        if (!bus1_HRESETn) begin
            state   <= IDLE;
            cmd     <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            count_q <= count_nxt;
        end
    end

    // A reset arriving during a write beat must not let that beat land,
    // since the memory itself is not reset and the command is aborted.
    cbm_resp_mem #(
        .AW (AW_WORDS)
    ) u_mem (
        .clk   (bus1_HCLK),
        .we    (mem_we && bus1_HRESETn),
        .addr  (mem_addr),
        .wdata (cbm_write_data),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs decode straight from the state register, so they all take
    // their idle values on the cycle following a reset edge.
    // ------------------------------------------------------------------
    assign cbm_command_busy = (state != IDLE);
    assign cbm_data_ready   = (state == WRITE) || (state == READ);
    assign cbm_error        = (state == ERR);
    assign cbm_count        = count_q;
    assign cbm_read_data    = (state == READ) ? mem_rdata : 32'h0000_0000;

    // The lock hint and the out-of-window address bits have no function.
    logic unused_ok;
    assign unused_ok = &{1'b0, cbm_lock, word_off};

endmodule

// File: doc/cbm_burst_responder.md
CBM_BURST_RESPONDER -- requirements
Module: cbm_burst_responder

Interface
REQ-001 SHALL have parameter AW_WORDS, default 6, meaning log2 of local memory depth in 32-bit words (64 words, 256 bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte base of the decoded window.
REQ-003 bus1_HCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 bus1_HRESETn  in  1  reset, synchronous, active-low.
REQ-005 cbm_read_req  in  1  initiator read command request.
REQ-006 cbm_write_req  in  1  initiator write command request.
REQ-007 cbm_burst  in  3  burst type: 000 SINGLE, 001 INCR, 010 WRAP4; others illegal.
REQ-008 cbm_addr  in  32  start byte address.
REQ-009 cbm_length  in  11  beat count for INCR (1..1024; 0 means 1024).
REQ-010 cbm_size  in  3  transfer size; only 3'b010 (word) legal.
REQ-011 cbm_lock  in  1  locked-transfer hint; sampled, no functional effect.
REQ-012 cbm_write_data  in  32  write beat data.
REQ-013 cbm_read_data  out  32  read beat data, valid only with cbm_data_ready.
REQ-014 cbm_command_busy  out  1  high while a command is in progress; new requests ignored.
REQ-015 cbm_data_ready  out  1  one-cycle pulse per completed beat.
REQ-016 cbm_error  out  1  one-cycle pulse on rejected command.
REQ-017 cbm_count  out  11  beats completed in current/last command.

Function
REQ-018 FSM states IDLE, WRITE, RD_ADDR, READ, ERR SHALL be the only states.
REQ-019 In IDLE, a request SHALL be accepted on the cycle it is sampled high; command_busy SHALL rise the next cycle; count SHALL clear to 0 on accept.
REQ-020 Accept SHALL register burst, addr, length, size; beat total = 1 for SINGLE, 4 for WRAP4, cbm_length for INCR.
REQ-021 Command SHALL go to ERR if read_req and write_req both high, size != 010, addr[1:0] != 0, burst illegal, or any beat address falls outside BASE_ADDR .. BASE_ADDR+4*2^AW_WORDS-1.
REQ-022 ERR SHALL last one cycle: error=1, command_busy=1, no memory access, count=0, then IDLE.
REQ-023 WRITE: each cycle write_data SHALL be written to current word and data_ready pulsed; first beat on cycle after accept; one beat per cycle.
REQ-024 Read: RD_ADDR issues first address; first data_ready SHALL appear 2 cycles after accept, then one beat per cycle with no bubbles.
REQ-025 INCR/SINGLE address SHALL advance by 4 per beat; WRAP4 SHALL wrap within the 16-byte aligned block (e.g. start 0x0C -> 0x0C,0x00,0x04,0x08).
REQ-026 count SHALL increment with each data_ready and hold its final value until next accept.
REQ-027 After final beat, command_busy SHALL fall the next cycle and FSM return to IDLE; back-to-back request may be accepted on that same cycle.
REQ-028 Requests sampled while command_busy is high SHALL be ignored (not queued).
REQ-029 Beat counter SHALL be 11 bits with length 0 decoded as 1024; no wrap of count below final value.

Reset
REQ-030 With bus1_HRESETn low at a rising edge: FSM=IDLE, command_busy=0, data_ready=0, error=0, count=0, read_data=0.
REQ-031 Reset mid-burst SHALL abort the command with no further writes; memory contents SHALL NOT be reset.

Structure
REQ-032 Burst encodings, size encoding, and FSM state encoding SHALL live in shared package cbm_pkg.
REQ-033 Memory SHALL be a sub-module cbm_resp_mem: single-port, 2^AW_WORDS x 32, synchronous read (1-cycle latency), synchronous write.

Verification
REQ-034 INCR write addr 0x10 length 4 data 0xA0..0xA3, then INCR read same -> 4 data_ready pulses, read_data 0xA0,0xA1,0xA2,0xA3, count=4, first read beat 2 cycles after accept.
REQ-035 WRAP4 read at 0x0C after writing words 0..3 = 0,1,2,3 -> read_data 3,0,1,2.
REQ-036 size=000, or addr=0x102, or INCR addr 0xF8 length 4 -> error pulse one cycle, count=0, memory unchanged.
REQ-037 read_req and write_req high together -> error; request during command_busy -> ignored, no extra beats.
REQ-038 Reset asserted on beat 2 of an 8-beat write -> outputs at reset values next cycle, beats 0..1 retained, beats 2..7 unwritten.
REQ-039 INCR length 0 write -> 1024 beats wait? no: range check fails at default AW_WORDS -> error; with AW_WORDS=10 -> 1024 data_ready pulses, count=1024.
